// File: rtl/resize_coord_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resize_coord_pkg
// Description : Shared widths, fixed-point constants and FSM state encoding
//               for the resize coordinate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package resize_coord_pkg;

    localparam int IDX_W      = 20;  // index / length width
    localparam int SCALE_W    = 48;  // unsigned scale, Q16.32
    localparam int POS_W      = 42;  // signed position, Q20.22
    localparam int PROD_W     = 74;  // signed product, Q.54
    localparam int POS_FRAC   = 22;
    localparam int SCALE_FRAC = 32;

    // +0.5 in Q20.22
    localparam logic [POS_W-1:0] HALF_POS =
        {{(POS_W-POS_FRAC){1'b0}}, 1'b1, {(POS_FRAC-1){1'b0}}};

    // -0.5 in the Q.54 product domain (-2^53)
    localparam logic signed [PROD_W-1:0] NEG_HALF_PROD =
        {{(PROD_W-53){1'b1}}, 53'd0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/resize_coord_mul.sv
`default_nettype none
// ============================================================================
// Module      : resize_coord_mul
// Description : Pipelined unsigned 48-bit x signed 42-bit multiplier giving a
//               74-bit signed product. STAGES register levels, all gated by
//               ce so a stall freezes every level in place.
// Ports       : ap_clk, ap_rst_n (async active-low), ce,
//               a (unsigned scale), b (signed operand), p (signed product)
// Revision    : 1.0 - initial release
// ============================================================================
module resize_coord_mul
    import resize_coord_pkg::*;
#(
    parameter int STAGES = 5
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ce,
    input  logic [SCALE_W-1:0]       a,
    input  logic signed [POS_W-1:0]  b,
    output logic signed [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] r_pipe [STAGES];

    // Both operands are extended to the product width, so the signed multiply
    // yields exactly the low PROD_W bits of the true product.
    assign w_prod = $signed({{(PROD_W-SCALE_W){1'b0}}, a}) *
                    $signed({{(PROD_W-POS_W){b[POS_W-1]}}, b});

    // Product is formed ahead of the register chain; synthesis retimes the
    // multiplier logic across the levels.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (ce) begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign p = r_pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/resize_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : resize_coord_gen
// Description : Walks destination indices 0..out_len-1, computes the source
//               position (dst+0.5)*scale-0.5 in Q20.22 and emits a clamped
//               integer source index plus fractional weight on a
//               valid/ready stream.
// Ports       : ap_clk, ap_rst_n (async active-low)
//               start/out_len/in_len/scale - line request and configuration
//               busy, done                 - line status
//               coord_valid/coord_ready    - output handshake
//               coord_dst/idx/wgt/last     - output payload
// Options     : RESIZE_COORD_ROUND_EN - round weight to nearest instead of
//               truncating (same latency).
// Revision    : 1.0 - initial release
// ============================================================================
module resize_coord_gen
    import resize_coord_pkg::*;
#(
    parameter int WGT_W      = 8,
    parameter int MUL_STAGES = 5
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               start,
    input  logic [IDX_W-1:0]   out_len,
    input  logic [IDX_W-1:0]   in_len,
    input  logic [SCALE_W-1:0] scale,
    output logic               busy,
    output logic               done,
    output logic               coord_valid,
    input  logic               coord_ready,
    output logic [IDX_W-1:0]   coord_dst,
    output logic [IDX_W-1:0]   coord_idx,
    output logic [WGT_W-1:0]   coord_wgt,
    output logic               coord_last
);

    localparam logic [IDX_W-1:0] c_one_idx = IDX_W'(1);

    // ---------------- control ----------------
    state_t                r_state, w_state_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_accept;
    logic                  w_en;
    logic                  w_issue_last;
    logic                  w_last_hs;
    logic [IDX_W-1:0]      r_out_len, r_in_len, r_cnt;
    logic [SCALE_W-1:0]    r_scale;

    // ---------------- datapath ----------------
    logic                  r_s0_valid, r_s0_last;
    logic [IDX_W-1:0]      r_s0_dst;
    logic signed [POS_W-1:0]  w_s0_op;
    logic signed [PROD_W-1:0] w_prod, w_prod_adj;
    logic signed [POS_W-1:0]  w_pos;
    logic                  r_tag_valid [MUL_STAGES];
    logic                  r_tag_last  [MUL_STAGES];
    logic [IDX_W-1:0]      r_tag_dst   [MUL_STAGES];
    logic                  r_post_valid, r_post_last;
    logic [IDX_W-1:0]      r_post_dst;
    logic signed [POS_W-1:0] r_pos;
    logic [IDX_W-1:0]      w_int, w_last_idx, w_idx;
    logic [IDX_W:0]        w_int_ext;
    logic [WGT_W-1:0]      w_wgt_raw, w_wgt;
    logic                  r_coord_valid, r_coord_last;
    logic [IDX_W-1:0]      r_coord_dst, r_coord_idx;
    logic [WGT_W-1:0]      r_coord_wgt;

    // A stall holds every stage, so bubbles stay where they are.
    assign w_en         = !r_coord_valid || coord_ready;
    assign w_issue_last = (r_cnt == r_out_len - c_one_idx);
    assign w_last_hs    = r_coord_valid && coord_ready && r_coord_last;

    // ---------------- FSM ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (out_len != '0) begin
                        w_state_nxt = RUN;
                        w_accept    = 1'b1;
                    end else begin
                        // Empty line: report completion without running.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_en && w_issue_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- configuration and issue counter ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_len <= '0;
            r_in_len  <= '0;
            r_scale   <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_out_len <= out_len;
            r_in_len  <= in_len;
            r_scale   <= scale;
            r_cnt     <= '0;
        end else if (r_state == RUN && w_en) begin
            r_cnt <= r_cnt + c_one_idx;
        end
    end

    // ---------------- stage 0: issue ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_dst   <= '0;
        end else if (w_en) begin
            r_s0_valid <= (r_state == RUN);
            r_s0_last  <= w_issue_last;
            r_s0_dst   <= r_cnt;
        end
    end

    // (dst + 0.5) in Q20.22
    assign w_s0_op = {r_s0_dst, {POS_FRAC{1'b0}}} | HALF_POS;

    // ---------------- multiply ----------------
    resize_coord_mul #(
        .STAGES (MUL_STAGES)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ce       (w_en),
        .a        (r_scale),
        .b        (w_s0_op),
        .p        (w_prod)
    );

    // Sideband travels alongside the multiplier with the same gating.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_tag_valid[i] <= 1'b0;
                r_tag_last[i]  <= 1'b0;
                r_tag_dst[i]   <= '0;
            end
        end else if (w_en) begin
            r_tag_valid[0] <= r_s0_valid;
            r_tag_last[0]  <= r_s0_last;
            r_tag_dst[0]   <= r_s0_dst;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_last[i]  <= r_tag_last[i-1];
                r_tag_dst[i]   <= r_tag_dst[i-1];
            end
        end
    end

    // ---------------- post stage: subtract 0.5, rescale to Q20.22 ----------------
    assign w_prod_adj = w_prod + NEG_HALF_PROD;
    assign w_pos      = POS_W'(w_prod_adj >>> SCALE_FRAC);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_post_valid <= 1'b0;
            r_post_last  <= 1'b0;
            r_post_dst   <= '0;
            r_pos        <= '0;
        end else if (w_en) begin
            r_post_valid <= r_tag_valid[MUL_STAGES-1];
            r_post_last  <= r_tag_last[MUL_STAGES-1];
            r_post_dst   <= r_tag_dst[MUL_STAGES-1];
            r_pos        <= w_pos;
        end
    end

    // ---------------- index / weight split ----------------
    assign w_int      = r_pos[POS_W-1:POS_FRAC];
    assign w_last_idx = r_in_len - c_one_idx;

`ifdef RESIZE_COORD_ROUND_EN
    // Half an output LSB, 2^(21-WGT_W), added to the fraction before slicing.
    localparam logic [POS_FRAC:0] c_rnd_add =
        {{(WGT_W+1){1'b0}}, 1'b1, {(POS_FRAC-1-WGT_W){1'b0}}};
    logic [POS_FRAC:0] w_frac_rnd;
    logic              w_carry;

    assign w_frac_rnd = {1'b0, r_pos[POS_FRAC-1:0]} + c_rnd_add;
    assign w_carry    = w_frac_rnd[POS_FRAC];
    // Carry rolls into the integer part before the clamp is evaluated.
    assign w_int_ext  = {1'b0, w_int} + {{IDX_W{1'b0}}, w_carry};
    assign w_wgt_raw  = w_carry ? '0 :
                        WGT_W'(w_frac_rnd[POS_FRAC-1:0] >> (POS_FRAC-WGT_W));
`else
    assign w_int_ext  = {1'b0, w_int};
    assign w_wgt_raw  = WGT_W'(r_pos[POS_FRAC-1:0] >> (POS_FRAC-WGT_W));
`endif

    always_comb begin
        w_idx = '0;
        w_wgt = '0;
        // Negative positions sit left of the first source pixel: index 0, weight 0.
        if (!r_pos[POS_W-1]) begin
            if (w_int_ext >= {1'b0, w_last_idx}) begin
                w_idx = w_last_idx;
            end else begin
                w_idx = w_int_ext[IDX_W-1:0];
                w_wgt = w_wgt_raw;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_coord_valid <= 1'b0;
            r_coord_last  <= 1'b0;
            r_coord_dst   <= '0;
            r_coord_idx   <= '0;
            r_coord_wgt   <= '0;
        end else if (w_en) begin
            r_coord_valid <= r_post_valid;
            r_coord_last  <= r_post_last;
            r_coord_dst   <= r_post_dst;
            r_coord_idx   <= w_idx;
            r_coord_wgt   <= w_wgt;
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign coord_valid = r_coord_valid;
    assign coord_last  = r_coord_last;
    assign coord_dst   = r_coord_dst;
    assign coord_idx   = r_coord_idx;
    assign coord_wgt   = r_coord_wgt;

endmodule
`default_nettype wire

// File: tb/tb_resize_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_resize_coord_gen
// Description : Directed self-checking bench for resize_coord_gen. Expected
//               coordinates are hand-computed from (dst+0.5)*scale-0.5.
//               Honours RESIZE_COORD_ROUND_EN for the rounding vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resize_coord_gen;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        start;
    logic [19:0] out_len, in_len;
    logic [47:0] scale;
    logic        busy, done, coord_valid, coord_ready, coord_last;
    logic [19:0] coord_dst, coord_idx;
    logic [7:0]  coord_wgt;

    int checks   = 0;
    int failures = 0;

    logic [19:0] e_idx [8];
    logic [7:0]  e_wgt [8];

    resize_coord_gen dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .start       (start),
        .out_len     (out_len),
        .in_len      (in_len),
        .scale       (scale),
        .busy        (busy),
        .done        (done),
        .coord_valid (coord_valid),
        .coord_ready (coord_ready),
        .coord_dst   (coord_dst),
        .coord_idx   (coord_idx),
        .coord_wgt   (coord_wgt),
        .coord_last  (coord_last)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one line and checks every valid cycle against e_idx/e_wgt.
    // bp: ready high for two results, low for 5 cycles, then toggling.
    // poke: re-issues start with a different config while the line runs.
    task automatic run_line(input logic [19:0] il, input logic [19:0] ol,
                            input logic [47:0] sc, input int n,
                            input bit bp, input bit chk_lat, input bit poke);
        int got, cyc, first, stall_n;
        bit tog;
        got = 0; cyc = 0; first = -1; stall_n = 0; tog = 1'b1;
        @(negedge ap_clk);
        start = 1'b1; in_len = il; out_len = ol; scale = sc; coord_ready = 1'b1;
        while (got < n && cyc < 300) begin
            @(negedge ap_clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (poke && cyc == 3) begin
                start = 1'b1; out_len = 20'd5; in_len = 20'd9; scale = 48'h3_0000_0000;
            end
            if (bp) begin
                if (got < 2) coord_ready = 1'b1;
                else if (stall_n < 5) begin coord_ready = 1'b0; stall_n++; end
                else begin coord_ready = tog; tog = !tog; end
            end else begin
                coord_ready = 1'b1;
            end
            if (coord_valid) begin
                if (first < 0) first = cyc - 1;
                chk("coord_dst", coord_dst, got);
                chk("coord_idx", coord_idx, e_idx[got]);
                chk("coord_wgt", coord_wgt, e_wgt[got]);
                chk("coord_last", coord_last, (got == n - 1));
                if (coord_ready) got++;
            end
        end
        start = 1'b0;
        coord_ready = 1'b1;
        chk("line_complete", got, n);
        if (chk_lat) chk("first_valid_latency", first, 8);
        @(negedge ap_clk);
        chk("done_pulse", done, 1);
        chk("busy_clear", busy, 0);
        chk("valid_clear", coord_valid, 0);
        @(negedge ap_clk);
        chk("done_one_cycle", done, 0);
        chk("no_extra_valid", coord_valid, 0);
    endtask

    initial begin
        ap_rst_n = 1'b0; start = 1'b0; out_len = '0; in_len = '0;
        scale = '0; coord_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", coord_valid, 0);
        chk("rst_dst", coord_dst, 0);
        chk("rst_idx", coord_idx, 0);
        chk("rst_wgt", coord_wgt, 0);
        chk("rst_last", coord_last, 0);
        ap_rst_n = 1'b1;

        // Downscale x2: pos 0.5, 2.5
        e_idx[0] = 20'd0; e_wgt[0] = 8'd128;
        e_idx[1] = 20'd2; e_wgt[1] = 8'd128;
        run_line(20'd4, 20'd2, 48'h2_0000_0000, 2, 1'b0, 1'b0, 1'b0);

        // Upscale x2 with clamping at both ends: pos -0.25, 0.25, 0.75, 1.25
        e_idx[0] = 20'd0; e_wgt[0] = 8'd0;
        e_idx[1] = 20'd0; e_wgt[1] = 8'd64;
        e_idx[2] = 20'd0; e_wgt[2] = 8'd192;
        e_idx[3] = 20'd1; e_wgt[3] = 8'd0;
        run_line(20'd2, 20'd4, 48'h0_8000_0000, 4, 1'b0, 1'b0, 1'b0);

        // Identity with latency check and an ignored start mid-line
        e_idx[0] = 20'd0; e_wgt[0] = 8'd0;
        e_idx[1] = 20'd1; e_wgt[1] = 8'd0;
        e_idx[2] = 20'd2; e_wgt[2] = 8'd0;
        run_line(20'd3, 20'd3, 48'h1_0000_0000, 3, 1'b0, 1'b1, 1'b1);

        // Backpressure, scale 0.75, in_len 6: pos = 0.75*dst - 0.125
        e_idx[0] = 20'd0; e_wgt[0] = 8'd0;
        e_idx[1] = 20'd0; e_wgt[1] = 8'd160;
        e_idx[2] = 20'd1; e_wgt[2] = 8'd96;
        e_idx[3] = 20'd2; e_wgt[3] = 8'd32;
        e_idx[4] = 20'd2; e_wgt[4] = 8'd224;
        e_idx[5] = 20'd3; e_wgt[5] = 8'd160;
        e_idx[6] = 20'd4; e_wgt[6] = 8'd96;
        e_idx[7] = 20'd5; e_wgt[7] = 8'd0;
        run_line(20'd6, 20'd8, 48'h0_C000_0000, 8, 1'b1, 1'b0, 1'b0);

        // Rounding: pos = 0x3FFE00 (0.99988)
`ifdef RESIZE_COORD_ROUND_EN
        e_idx[0] = 20'd1; e_wgt[0] = 8'd0;
`else
        e_idx[0] = 20'd0; e_wgt[0] = 8'd255;
`endif
        run_line(20'd4, 20'd1, 48'h2_FFF0_0000, 1, 1'b0, 1'b0, 1'b0);

        // Empty line
        @(negedge ap_clk);
        start = 1'b1; out_len = 20'd0; in_len = 20'd4; scale = 48'h1_0000_0000;
        @(negedge ap_clk);
        start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_valid", coord_valid, 0);
        @(negedge ap_clk);
        chk("empty_done_one_cycle", done, 0);
        chk("empty_no_valid", coord_valid, 0);

        // Reset in the middle of a line
        @(negedge ap_clk);
        start = 1'b1; out_len = 20'd8; in_len = 20'd8; scale = 48'h1_0000_0000;
        coord_ready = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        repeat (10) @(negedge ap_clk);
        chk("midline_valid", coord_valid, 1);
        chk("midline_dst", coord_dst, 2);
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", coord_valid, 0);
        chk("async_rst_dst", coord_dst, 0);
        chk("async_rst_idx", coord_idx, 0);
        chk("async_rst_last", coord_last, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge ap_clk);
            chk("post_rst_quiet", {done, coord_valid, busy}, 0);
        end

        // Clean line after reset
        e_idx[0] = 20'd0; e_wgt[0] = 8'd0;
        e_idx[1] = 20'd1; e_wgt[1] = 8'd0;
        e_idx[2] = 20'd2; e_wgt[2] = 8'd0;
        run_line(20'd3, 20'd3, 48'h1_0000_0000, 3, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/resize_coord_gen.md
Name: resize_coord_gen

Overview:
- Sequencer side of the resize coordinate mapping.
- Walks destination indices 0..out_len-1 and computes each source position as pos = (dst+0.5)*scale - 0.5 in signed Q20.22.
- Splits each position into a clamped integer source index and a fractional interpolation weight.
- Streams results over a valid/ready interface to the line-buffer/interpolator in the resize pipeline.

Parameters:
- IDX_W, 20, width of destination/source indices and lengths
- SCALE_W, 48, width of unsigned scale, Q16.32 (SCALE_FRAC=32)
- POS_W, 42, width of signed position, Q20.22 (POS_FRAC=22)
- WGT_W, 8, width of output fractional weight
- MUL_STAGES, 5, pipeline depth of the multiplier

Ports:
- ap_clk, in, 1, clock
- ap_rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle request to begin a line; sampled only in IDLE
- out_len, in, IDX_W, destination length; latched on accepted start
- in_len, in, IDX_W, source length, >=1; latched on accepted start
- scale, in, SCALE_W, in_len/out_len in Q16.32; latched on accepted start
- busy, out, 1, high from accepted start until done
- done, out, 1, one-cycle pulse at line completion
- coord_valid, out, 1, output data valid
- coord_ready, in, 1, consumer ready
- coord_dst, out, IDX_W, destination index for this result
- coord_idx, out, IDX_W, clamped integer source index
- coord_wgt, out, WGT_W, fractional weight toward coord_idx+1
- coord_last, out, 1, high with the result for dst = out_len-1

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE, counters 0, all stage valids 0, busy=0, done=0, coord_valid=0, coord_dst/idx/wgt=0, coord_last=0.
- FSM states:
  - IDLE: start=1 and out_len!=0 -> RUN, latch cfg, issue counter=0. start=1 and out_len==0 -> done pulse next cycle, stay IDLE. start outside IDLE is ignored.
  - RUN: issue one index per enabled cycle. After issuing out_len-1 -> DRAIN.
  - DRAIN: no issue. Last result handshake (coord_valid & coord_ready & coord_last) -> IDLE with done=1 for one cycle. busy drops in the same cycle.
- Pipeline enable en = !coord_valid | coord_ready. All stages, including the multiplier ce, advance only when en=1; a stall freezes every stage, and bubbles are not compressed.
- Stage 0: operand = {dst[19:0], 22'd0} | 2^21, i.e. (dst+0.5) in Q20.22, 42-bit signed.
- Multiply: unsigned 48-bit x signed 42-bit -> 74-bit signed product, MUL_STAGES deep.
- Post stage:
  - Add -2^53 (-0.5 at Q.54), take bits [73:32] -> pos (Q20.22).
  - pos<0 -> idx=0, wgt=0.
  - Otherwise int=pos[41:22], wgt=pos[21:22-WGT_W].
  - int>=in_len-1 -> idx=in_len-1, wgt=0.
  - Otherwise idx=int.
- Output register loads when en=1. coord_* are held stable while coord_valid=1 and coord_ready=0.
- Latency: start edge to first coord_valid = MUL_STAGES+3 cycles with no backpressure. Throughput is 1 result/cycle.
- coord_dst increments by exactly 1 per handshake: no drops, no duplicates.
- Reset mid-line discards all in-flight results; no done pulse is produced.

Optional Feature:
- Macro RESIZE_COORD_ROUND_EN.
- Defined: weight is rounded to nearest by adding 2^(21-WGT_W) before truncation. A carry out of the fraction increments int and sets wgt=0, and the clamp is applied after the carry.
- Undefined: weight is truncated. Latency is identical in both builds.

Decomposition:
- Package resize_coord_pkg:
  - width constants IDX_W, SCALE_W, POS_W, PROD_W=74, POS_FRAC, SCALE_FRAC
  - HALF_POS=2^21 and NEG_HALF_PROD=-2^53
  - FSM state enum {IDLE, RUN, DRAIN}
- One sub-module: resize_coord_mul, a pipelined 48u x 42s multiplier with ce and MUL_STAGES depth.

Test Plan:
- Downscale: in_len=4, out_len=2, scale=0x2_0000_0000 -> (dst0, idx0, wgt128), (dst1, idx2, wgt128, last); done pulse after the last handshake.
- Upscale with clamping: in_len=2, out_len=4, scale=0x0_8000_0000 -> (0,0,0), (1,0,64), (2,0,192), (3,1,0,last).
- Identity: in_len=out_len=3, scale=0x1_0000_0000 -> idx=dst, wgt=0. First valid appears exactly MUL_STAGES+3 cycles after start.
- Backpressure: out_len=8, coord_ready low for 5 cycles mid-stream, and toggling every cycle thereafter -> outputs stable while stalled; dst sequence 0..7 exactly once each.
- Rounding: in_len=4, out_len=1, scale=0x2_FFF0_0000 -> without the macro idx0, wgt255; with RESIZE_COORD_ROUND_EN idx1, wgt0.
- Edge and control cases:
  - out_len=0 -> done one cycle after start, no coord_valid.
  - start while busy -> ignored.
  - ap_rst_n asserted mid-line -> all outputs 0 immediately; the next start produces a clean line.
